// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: memop encodings and FSM states.
package dmem_pkg;

    // Memop encodings shared by the requesters and the memory port.
    localparam logic [2:0] MOP_LB  = 3'b000;
    localparam logic [2:0] MOP_LH  = 3'b001;
    localparam logic [2:0] MOP_LW  = 3'b010;
    localparam logic [2:0] MOP_LWX = 3'b110; // alias of lw (bit 2 is don't-care for words)
    localparam logic [2:0] MOP_LBU = 3'b100;
    localparam logic [2:0] MOP_LHU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } dmem_state_e;

endpackage

// File: rtl/dmem_req_check.sv
// Combinational request checker: flags bad memops, misaligned accesses and
// out-of-range word indices.
//   we_i     1=store, 0=load
//   memop_i  memop encoding
//   addr_i   byte address
//   err_o    1 when the access must not reach memory
module dmem_req_check
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 2048
) (
    input  logic        we_i,
    input  logic [2:0]  memop_i,
    input  logic [31:0] addr_i,
    output logic        err_o
);

    always_comb begin
        err_o = 1'b0;
        case (memop_i)
            MOP_LB:          err_o = 1'b0;
            MOP_LH:          err_o = addr_i[0];
            MOP_LW, MOP_LWX: err_o = (addr_i[1:0] != 2'b00);
            // Unsigned variants are meaningless for stores.
            MOP_LBU:         err_o = we_i;
            MOP_LHU:         err_o = we_i | addr_i[0];
            default:         err_o = 1'b1;
        endcase
        if ({2'b00, addr_i[31:2]} >= DEPTH) begin
            err_o = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory. m0 has priority; m1 is
// forced through after MAX_WAIT consecutive losses. One access is in flight at a
// time: IDLE (grant) -> ISSUE (mem_en) -> WAIT (loads) -> RESP (rvalid).
//   clk, rst_n                    clock, async active-low reset
//   mN_req/we/memop/addr/datain   request side, held until mN_gnt
//   mN_gnt                        accept pulse (combinational in IDLE)
//   mN_rvalid/dataout/err         completion pulse with result
//   mem_en/we/memop/addr/datain   memory strobe and command, zero when idle
//   mem_dataout                   extended read data, RD_LAT cycles after mem_en
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH    = 2048,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [2:0]  m0_memop,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_datain,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_dataout,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [2:0]  m1_memop,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_datain,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_dataout,
    output logic        m1_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [2:0]  mem_memop,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_datain,
    input  logic [31:0] mem_dataout
);

    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
    localparam int unsigned LatW = $clog2(RD_LAT + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(MAX_WAIT);
    localparam logic [LatW-1:0] LatLast = LatW'(RD_LAT);

    dmem_state_e     state_q, state_d;
    logic            owner_q, owner_d;
    logic            we_q, we_d;
    logic [2:0]      memop_q, memop_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     datain_q, datain_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [LatW-1:0] lat_q, lat_d;

    logic        sel_m1;
    logic        sel_we;
    logic [2:0]  sel_memop;
    logic [31:0] sel_addr;
    logic [31:0] sel_datain;
    logic        sel_err;

    assign sel_m1     = m1_req & (~m0_req | (cnt_q == CntMax));
    assign sel_we     = sel_m1 ? m1_we     : m0_we;
    assign sel_memop  = sel_m1 ? m1_memop  : m0_memop;
    assign sel_addr   = sel_m1 ? m1_addr   : m0_addr;
    assign sel_datain = sel_m1 ? m1_datain : m0_datain;

    dmem_req_check #(
        .DEPTH (DEPTH)
    ) u_req_check (
        .we_i    (sel_we),
        .memop_i (sel_memop),
        .addr_i  (sel_addr),
        .err_o   (sel_err)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        memop_d  = memop_q;
        addr_d   = addr_q;
        datain_d = datain_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        lat_d    = lat_q;
        m0_gnt   = 1'b0;
        m1_gnt   = 1'b0;

        // Starvation count only tracks an uninterrupted m1 request.
        if (!m1_req) begin
            cnt_d = '0;
        end

        case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    m0_gnt   = ~sel_m1;
                    m1_gnt   = sel_m1;
                    owner_d  = sel_m1;
                    we_d     = sel_we;
                    memop_d  = sel_memop;
                    addr_d   = sel_addr;
                    datain_d = sel_datain;
                    err_d    = sel_err;
                    rdata_d  = '0;
                    if (sel_m1) begin
                        cnt_d = '0;
                    end else if (m1_req && (cnt_q != CntMax)) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (err_q || we_q) begin
                    state_d = StResp;
                end else begin
                    lat_d   = LatW'(1);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (lat_q == LatLast) begin
                    rdata_d = mem_dataout;
                    state_d = StResp;
                end else begin
                    lat_d = lat_q + LatW'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            memop_q  <= '0;
            addr_q   <= '0;
            datain_q <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            lat_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            memop_q  <= memop_d;
            addr_q   <= addr_d;
            datain_q <= datain_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            lat_q    <= lat_d;
        end
    end

    // rdata_q is cleared at grant and only loaded for good loads, so stores
    // and errors return zero without extra gating.
    always_comb begin
        mem_en     = (state_q == StIssue) & ~err_q;
        mem_we     = mem_en & we_q;
        mem_memop  = mem_en ? memop_q  : '0;
        mem_addr   = mem_en ? addr_q   : '0;
        mem_datain = mem_en ? datain_q : '0;
        m0_rvalid  = (state_q == StResp) & ~owner_q;
        m1_rvalid  = (state_q == StResp) & owner_q;
        m0_err     = m0_rvalid & err_q;
        m1_err     = m1_rvalid & err_q;
        m0_dataout = m0_rvalid ? rdata_q : '0;
        m1_dataout = m1_rvalid ? rdata_q : '0;
    end

endmodule
